// File: rtl/nios2_ocimem_arb_pkg.sv
// Shared types and jdo field offsets for the OCI RAM arbiter.
package nios2_ocimem_arb_pkg;

  typedef enum logic {IDLE, RD} state_t;

  typedef enum logic {GNT_AVS, GNT_JTAG} grant_t;

  // Kind of JTAG command held in the pending slot
  typedef enum logic [1:0] {
    JOP_LOAD,     // load the address pointer only; no RAM access
    JOP_LOAD_RD,  // load the address pointer, then read at the new address
    JOP_RD,       // read at the current address pointer
    JOP_WR        // write at the current address pointer
  } jop_t;

  localparam int JDO_ADDR_LSB  = 17;
  localparam int JDO_RD_BIT    = 34;
  localparam int JDO_WDATA_MSB = 34;
  localparam int JDO_WDATA_LSB = 3;

  // Strobe-to-command decode; ocimem_a takes precedence, then no_action_a, then b
  function automatic jop_t decode_jop(input logic act_a, input logic no_act_a,
                                      input logic rd_bit);
    if (act_a)    return rd_bit ? JOP_LOAD_RD : JOP_LOAD;
    if (no_act_a) return JOP_RD;
    return JOP_WR;
  endfunction

endpackage

// File: rtl/nios2_ocimem_arbiter_rr_grant.sv
// Two-requester grant for the OCI RAM port.
// Define NIOS2_OCIMEM_ARB_JTAG_PRIO_EN for fixed JTAG priority; the default
// build alternates conflicting grants using a last_grant register.
module nios2_ocimem_rr_grant
  import nios2_ocimem_arb_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  input  logic   req_avs,
  input  logic   req_jtag,
  output logic   gnt_valid,
  output grant_t gnt
);

  assign gnt_valid = en & (req_avs | req_jtag);

`ifdef NIOS2_OCIMEM_ARB_JTAG_PRIO_EN
  assign gnt = req_jtag ? GNT_JTAG : GNT_AVS;
`else
  grant_t last_grant;

  // Pick the requester that did not win last time when both are asking
  always_comb begin
    // NOTE: default first so every path assigns gnt and no latch is inferred.
    gnt = GNT_AVS;
    if (req_avs && req_jtag) gnt = (last_grant == GNT_AVS) ? GNT_JTAG : GNT_AVS;
    else if (req_jtag)       gnt = GNT_JTAG;
  end

  // Remember the most recent winner; starting at Avalon lets JTAG win the first conflict
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst)            last_grant <= GNT_AVS;
    else if (gnt_valid) last_grant <= gnt;
  end
`endif

endmodule

// File: rtl/nios2_ocimem_arbiter.sv
// Shares the single-port OCI RAM between JTAG debug commands and the
// Avalon debug_mem_slave. Optional macro: NIOS2_OCIMEM_ARB_JTAG_PRIO_EN
// (fixed JTAG priority instead of round-robin).
module nios2_ocimem_arbiter
  import nios2_ocimem_arb_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [37:0]       jdo,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              jtag_overrun,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  state_t            state;
  grant_t            rd_owner;
  logic              slot_full;
  jop_t              slot_op;
  logic [ADDR_W-1:0] slot_addr;
  logic [DATA_W-1:0] slot_data;
  logic [ADDR_W-1:0] jaddr;

  logic              strobe, accept, slot_pop;
  logic              avs_req, jtag_req, arb_en;
  logic              gnt_valid, jtag_go, avs_go, jtag_rd_done;
  grant_t            gnt;
  logic [ADDR_W-1:0] jtag_addr;
  logic              unused_jdo;

  assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

  assign strobe   = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign avs_req  = avs_read | avs_write;
  // Address-only loads never touch the RAM, so they do not compete for it
  assign jtag_req = slot_full & (slot_op != JOP_LOAD);
  // No grant while reset is held, so no RAM write can slip out
  assign arb_en   = (state == IDLE) & ~reset;

  nios2_ocimem_rr_grant u_grant (
    .clk       (clk),
    .rst       (reset),
    .en        (arb_en),
    .req_avs   (avs_req),
    .req_jtag  (jtag_req),
    .gnt_valid (gnt_valid),
    .gnt       (gnt)
  );

  assign jtag_go      = gnt_valid & (gnt == GNT_JTAG);
  assign avs_go       = gnt_valid & (gnt == GNT_AVS);
  assign slot_pop     = jtag_go | (slot_full & (slot_op == JOP_LOAD));
  // A slot being emptied this cycle can take the next strobe straight away
  assign accept       = strobe & (~slot_full | slot_pop);
  assign jtag_addr    = (slot_op == JOP_LOAD_RD) ? slot_addr : jaddr;
  assign jtag_rd_done = (state == RD) & (rd_owner == GNT_JTAG);

  // Drive the RAM port for whichever requester is granted this cycle
  always_comb begin
    ram_addr  = '0;
    ram_wren  = 1'b0;
    ram_wdata = '0;
    if (jtag_go) begin
      ram_addr = jtag_addr;
      if (slot_op == JOP_WR) begin
        ram_wren  = 1'b1;
        ram_wdata = slot_data;
      end
    end else if (avs_go) begin
      ram_addr = avs_address;
      if (avs_write) begin
        ram_wren  = 1'b1;
        ram_wdata = avs_writedata;
      end
    end
  end

  // Writes complete in their grant cycle, reads in the RD cycle that follows
  assign avs_waitrequest = ~((avs_go & avs_write) | ((state == RD) & (rd_owner == GNT_AVS)));
  assign avs_readdata    = ((state == RD) && (rd_owner == GNT_AVS)) ? ram_rdata : '0;

  // One-deep JTAG command slot
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: the slot payload is reset along with the valid bit; it is a few
    // flops, not a memory array, and a clean value keeps ram_wdata defined.
    if (reset) begin
      slot_full <= 1'b0;
      slot_op   <= JOP_LOAD;
      slot_addr <= '0;
      slot_data <= '0;
    end else if (accept) begin
      slot_full <= 1'b1;
      slot_op   <= decode_jop(take_action_ocimem_a, take_no_action_ocimem_a, jdo[JDO_RD_BIT]);
      slot_addr <= jdo[JDO_ADDR_LSB +: ADDR_W];
      slot_data <= jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
    end else if (slot_pop) begin
      slot_full <= 1'b0;
    end
  end

  // JTAG address pointer: load on ocimem_a, post-increment after each access
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      jaddr <= '0;
    end else if (slot_pop) begin
      case (slot_op)
        JOP_LOAD:    jaddr <= slot_addr;
        JOP_LOAD_RD: jaddr <= slot_addr + ADDR_W'(1);
        default:     jaddr <= jaddr + ADDR_W'(1);
      endcase
    end
  end

  // Access sequencer: grants happen in IDLE, reads spend one cycle in RD
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      rd_owner <= GNT_AVS;
    end else begin
      case (state)
        IDLE: begin
          if (jtag_go && (slot_op != JOP_WR)) begin
            state    <= RD;
            rd_owner <= GNT_JTAG;
          end else if (avs_go && !avs_write) begin
            state    <= RD;
            rd_owner <= GNT_AVS;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Return JTAG read data; a newly accepted command hides stale readiness
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      MonDReg       <= '0;
      monitor_ready <= 1'b0;
    end else begin
      if (jtag_rd_done) MonDReg <= ram_rdata;
      if (accept)            monitor_ready <= 1'b0;
      else if (jtag_rd_done) monitor_ready <= 1'b1;
    end
  end

  // Sticky flag for strobes that found the slot occupied
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 jtag_overrun <= 1'b0;
    else if (strobe && !accept) jtag_overrun <= 1'b1;
  end

endmodule

// File: tb/tb_nios2_ocimem_arbiter.sv
// Directed bench for nios2_ocimem_arbiter with a registered-read RAM model.
module tb_nios2_ocimem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ta_a, tna_a, ta_b;
  logic [37:0] jdo;
  logic [31:0] mon_d;
  logic        mon_rdy, ovr;
  logic [7:0]  avs_address;
  logic        avs_read, avs_write;
  logic [31:0] avs_writedata, avs_readdata;
  logic        avs_waitrequest;
  logic [7:0]  ram_addr;
  logic        ram_wren;
  logic [31:0] ram_wdata, ram_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  nios2_ocimem_arbiter dut (
    .clk                     (clk),
    .reset                   (rst),
    .take_action_ocimem_a    (ta_a),
    .take_no_action_ocimem_a (tna_a),
    .take_action_ocimem_b    (ta_b),
    .jdo                     (jdo),
    .MonDReg                 (mon_d),
    .monitor_ready           (mon_rdy),
    .jtag_overrun            (ovr),
    .avs_address             (avs_address),
    .avs_read                (avs_read),
    .avs_write               (avs_write),
    .avs_writedata           (avs_writedata),
    .avs_readdata            (avs_readdata),
    .avs_waitrequest         (avs_waitrequest),
    .ram_addr                (ram_addr),
    .ram_wren                (ram_wren),
    .ram_wdata               (ram_wdata),
    .ram_rdata               (ram_rdata)
  );

  function automatic logic [31:0] init_word(input int i);
    case (i)
      5:       return 32'hA5A5_0005;
      16:      return 32'hDEAD_BEEF;
      default: return 32'h1000_0000 | 32'(i);
    endcase
  endfunction

  // RAM model: reloaded while reset is held, 1-cycle registered read
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
    end else if (ram_wren) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [37:0] mk_jdo(input logic is_b, input logic [7:0] addr,
                                         input logic rd, input logic [31:0] wd);
    logic [37:0] j;
    j = '0;
    if (is_b) begin
      j[34:3] = wd;
    end else begin
      j[24:17] = addr;
      j[34]    = rd;
    end
    return j;
  endfunction

  task automatic clr();
    ta_a = 1'b0; tna_a = 1'b0; ta_b = 1'b0; jdo = '0;
    avs_read = 1'b0; avs_write = 1'b0; avs_address = '0; avs_writedata = '0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ram(input string t, input logic [7:0] a, input logic w,
                         input logic [31:0] d, input logic wt);
    check({t, " ram_addr"}, 32'(ram_addr), 32'(a));
    check({t, " ram_wren"}, 32'(ram_wren), 32'(w));
    check({t, " ram_wdata"}, ram_wdata, d);
    check({t, " avs_waitrequest"}, 32'(avs_waitrequest), 32'(wt));
  endtask

  task automatic chk_jtag(input string t, input logic [31:0] m, input logic r, input logic o);
    check({t, " MonDReg"}, mon_d, m);
    check({t, " monitor_ready"}, 32'(mon_rdy), 32'(r));
    check({t, " jtag_overrun"}, 32'(ovr), 32'(o));
  endtask

  typedef struct {
    logic        a, na, b;
    logic [7:0]  jad;
    logic        jrd;
    logic [31:0] jwd;
    logic        ar;
    logic [7:0]  aa;
    logic [7:0]  e_addr;
    logic        e_wren;
    logic [31:0] e_wd;
    logic        e_wait;
    logic [31:0] e_ard;
    logic [31:0] e_mon;
    logic        e_rdy;
  } vec_t;

  vec_t vecs [18];

  function automatic vec_t mk(input logic a, input logic na, input logic b,
                              input logic [7:0] jad, input logic jrd, input logic [31:0] jwd,
                              input logic ar, input logic [7:0] aa,
                              input logic [7:0] e_addr, input logic e_wren, input logic [31:0] e_wd,
                              input logic e_wait, input logic [31:0] e_ard,
                              input logic [31:0] e_mon, input logic e_rdy);
    vec_t v;
    v.a = a; v.na = na; v.b = b; v.jad = jad; v.jrd = jrd; v.jwd = jwd;
    v.ar = ar; v.aa = aa;
    v.e_addr = e_addr; v.e_wren = e_wren; v.e_wd = e_wd; v.e_wait = e_wait;
    v.e_ard = e_ard; v.e_mon = e_mon; v.e_rdy = e_rdy;
    return v;
  endfunction

  initial begin
    // One row per cycle: inputs driven in that cycle, outputs expected in that cycle.
    //              a  na b  jad    rd jwd            ar aa     addr   wr wd             wt ard            mon            rdy
    vecs[0]  = mk(0, 0, 0, 8'h00, 0, 32'h0,         0, 8'h00, 8'h00, 0, 32'h0,         1, 32'h0,         32'h0,         0);
    vecs[1]  = mk(0, 0, 0, 8'h00, 0, 32'h0,         1, 8'h05, 8'h05, 0, 32'h0,         1, 32'h0,         32'h0,         0);
    vecs[2]  = mk(0, 0, 0, 8'h00, 0, 32'h0,         1, 8'h05, 8'h00, 0, 32'h0,         0, 32'hA5A5_0005, 32'h0,         0);
    vecs[3]  = mk(0, 0, 0, 8'h00, 0, 32'h0,         0, 8'h00, 8'h00, 0, 32'h0,         1, 32'h0,         32'h0,         0);
    vecs[4]  = mk(1, 0, 0, 8'h10, 1, 32'h0,         0, 8'h00, 8'h00, 0, 32'h0,         1, 32'h0,         32'h0,         0);
    vecs[5]  = mk(0, 0, 0, 8'h00, 0, 32'h0,         0, 8'h00, 8'h10, 0, 32'h0,         1, 32'h0,         32'h0,         0);
    vecs[6]  = mk(0, 0, 0, 8'h00, 0, 32'h0,         0, 8'h00, 8'h00, 0, 32'h0,         1, 32'h0,         32'h0,         0);
    vecs[7]  = mk(0, 0, 0, 8'h00, 0, 32'h0,         0, 8'h00, 8'h00, 0, 32'h0,         1, 32'h0,         32'hDEAD_BEEF, 1);
    vecs[8]  = mk(1, 0, 0, 8'hFF, 0, 32'h0,         0, 8'h00, 8'h00, 0, 32'h0,         1, 32'h0,         32'hDEAD_BEEF, 1);
    vecs[9]  = mk(0, 0, 1, 8'h00, 0, 32'h1234_5678, 0, 8'h00, 8'h00, 0, 32'h0,         1, 32'h0,         32'hDEAD_BEEF, 0);
    vecs[10] = mk(0, 0, 0, 8'h00, 0, 32'h0,         0, 8'h00, 8'hFF, 1, 32'h1234_5678, 1, 32'h0,         32'hDEAD_BEEF, 0);
    vecs[11] = mk(0, 1, 0, 8'h00, 0, 32'h0,         0, 8'h00, 8'h00, 0, 32'h0,         1, 32'h0,         32'hDEAD_BEEF, 0);
    vecs[12] = mk(0, 0, 0, 8'h00, 0, 32'h0,         0, 8'h00, 8'h00, 0, 32'h0,         1, 32'h0,         32'hDEAD_BEEF, 0);
    vecs[13] = mk(0, 0, 0, 8'h00, 0, 32'h0,         0, 8'h00, 8'h00, 0, 32'h0,         1, 32'h0,         32'hDEAD_BEEF, 0);
    vecs[14] = mk(1, 0, 0, 8'hFF, 1, 32'h0,         0, 8'h00, 8'h00, 0, 32'h0,         1, 32'h0,         32'h1000_0000, 1);
    vecs[15] = mk(0, 0, 0, 8'h00, 0, 32'h0,         0, 8'h00, 8'hFF, 0, 32'h0,         1, 32'h0,         32'h1000_0000, 0);
    vecs[16] = mk(0, 0, 0, 8'h00, 0, 32'h0,         0, 8'h00, 8'h00, 0, 32'h0,         1, 32'h0,         32'h1000_0000, 0);
    vecs[17] = mk(0, 0, 0, 8'h00, 0, 32'h0,         0, 8'h00, 8'h00, 0, 32'h0,         1, 32'h0,         32'h1234_5678, 1);

    clr();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #3;
    chk_ram("reset", 8'h00, 1'b0, 32'h0, 1'b1);
    chk_jtag("reset", 32'h0, 1'b0, 1'b0);
    check("reset avs_readdata", avs_readdata, 32'h0);
    next();

    // Table: Avalon read, JTAG read at 0x10, write at 0xFF with pointer wrap
    for (int i = 0; i < 18; i++) begin
      clr();
      ta_a = vecs[i].a; tna_a = vecs[i].na; ta_b = vecs[i].b;
      jdo = mk_jdo(vecs[i].b, vecs[i].jad, vecs[i].jrd, vecs[i].jwd);
      avs_read = vecs[i].ar; avs_address = vecs[i].aa;
      #3;
      chk_ram($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_wren, vecs[i].e_wd, vecs[i].e_wait);
      check($sformatf("vec%0d avs_readdata", i), avs_readdata, vecs[i].e_ard);
      chk_jtag($sformatf("vec%0d", i), vecs[i].e_mon, vecs[i].e_rdy, 1'b0);
      next();
    end

    // Reset while an Avalon read sits in RD and a JTAG write waits in the slot
    clr(); avs_read = 1'b1; avs_address = 8'h05;
    ta_b = 1'b1; jdo = mk_jdo(1'b1, 8'h00, 1'b0, 32'hBAD0_BAD0);
    #3; chk_ram("rstmid grant", 8'h05, 1'b0, 32'h0, 1'b1);
    next();
    clr(); avs_read = 1'b1; avs_address = 8'h05;
    #3;
    check("rstmid rd waitrequest", 32'(avs_waitrequest), 32'h0);
    check("rstmid rd readdata", avs_readdata, 32'hA5A5_0005);
    rst = 1'b1; avs_read = 1'b0;
    #1; check("rstmid async waitrequest", 32'(avs_waitrequest), 32'h1);
    next();
    rst = 1'b0;
    #3;
    chk_ram("rstmid after", 8'h00, 1'b0, 32'h0, 1'b1);
    chk_jtag("rstmid after", 32'h0, 1'b0, 1'b0);
    check("rstmid after readdata", avs_readdata, 32'h0);
    next();
    #3; check("rstmid slot dropped c1 ram_wren", 32'(ram_wren), 32'h0);
    next();
    #3; check("rstmid slot dropped c2 ram_wren", 32'(ram_wren), 32'h0);
    next();

    // Conflict 1 (last grant = Avalon after reset): JTAG read wins, Avalon write follows
    clr(); tna_a = 1'b1;
    #3; chk_ram("cf1 strobe", 8'h00, 1'b0, 32'h0, 1'b1);
    next();
    clr(); avs_write = 1'b1; avs_address = 8'h20; avs_writedata = 32'hCAFE_0020;
    #3; chk_ram("cf1 jtag first", 8'h00, 1'b0, 32'h0, 1'b1);
    next();
    clr(); avs_write = 1'b1; avs_address = 8'h20; avs_writedata = 32'hCAFE_0020;
    #3; chk_ram("cf1 rd", 8'h00, 1'b0, 32'h0, 1'b1);
    next();
    clr(); avs_write = 1'b1; avs_address = 8'h20; avs_writedata = 32'hCAFE_0020;
    #3;
    chk_ram("cf1 avs after", 8'h20, 1'b1, 32'hCAFE_0020, 1'b0);
    chk_jtag("cf1 avs after", 32'h1000_0000, 1'b1, 1'b0);
    next();

    // Lone JTAG write at pointer 0x01 so JTAG becomes the last granted
    clr(); ta_b = 1'b1; jdo = mk_jdo(1'b1, 8'h00, 1'b0, 32'h0BAD_F00D);
    #3; chk_ram("lone wr strobe", 8'h00, 1'b0, 32'h0, 1'b1);
    next();
    clr();
    #3; chk_ram("lone wr exec", 8'h01, 1'b1, 32'h0BAD_F00D, 1'b1);
    next();

    // Conflict 2: JTAG read at 0x02 against Avalon write to 0x20
    clr(); tna_a = 1'b1;
    #3; chk_ram("cf2 strobe", 8'h00, 1'b0, 32'h0, 1'b1);
    next();
`ifdef NIOS2_OCIMEM_ARB_JTAG_PRIO_EN
    clr(); avs_write = 1'b1; avs_address = 8'h20; avs_writedata = 32'h55AA_0020;
    #3; chk_ram("cf2 jtag first", 8'h02, 1'b0, 32'h0, 1'b1);
    next();
    clr(); avs_write = 1'b1; avs_address = 8'h20; avs_writedata = 32'h55AA_0020;
    #3; chk_ram("cf2 rd", 8'h00, 1'b0, 32'h0, 1'b1);
    next();
    clr(); avs_write = 1'b1; avs_address = 8'h20; avs_writedata = 32'h55AA_0020;
    #3; chk_ram("cf2 avs after", 8'h20, 1'b1, 32'h55AA_0020, 1'b0);
    next();
`else
    clr(); avs_write = 1'b1; avs_address = 8'h20; avs_writedata = 32'h55AA_0020;
    #3; chk_ram("cf2 avs first", 8'h20, 1'b1, 32'h55AA_0020, 1'b0);
    next();
    clr();
    #3; chk_ram("cf2 jtag after", 8'h02, 1'b0, 32'h0, 1'b1);
    next();
`endif
    clr();
    next();
    clr();
    #3; chk_jtag("cf2 read data", 32'h1000_0002, 1'b1, 1'b0);
    next();

    // Avalon read back of 0x20: one wait state, then data
    clr(); avs_read = 1'b1; avs_address = 8'h20;
    #3; chk_ram("avs rd20 grant", 8'h20, 1'b0, 32'h0, 1'b1);
    next();
    clr(); avs_read = 1'b1; avs_address = 8'h20;
    #3;
    check("avs rd20 waitrequest", 32'(avs_waitrequest), 32'h0);
    check("avs rd20 readdata", avs_readdata, 32'h55AA_0020);
    next();

    // Three JTAG strobes back to back during an Avalon read: run, hold, drop
    clr(); avs_read = 1'b1; avs_address = 8'h05;
    #3; chk_ram("ovr avs grant", 8'h05, 1'b0, 32'h0, 1'b1);
    next();
    clr(); avs_read = 1'b1; avs_address = 8'h05; tna_a = 1'b1;
    #3;
    check("ovr avs rd readdata", avs_readdata, 32'hA5A5_0005);
    chk_ram("ovr s1", 8'h00, 1'b0, 32'h0, 1'b0);
    next();
    clr(); ta_b = 1'b1; jdo = mk_jdo(1'b1, 8'h00, 1'b0, 32'h7777_7777);
    #3;
    chk_ram("ovr s2", 8'h03, 1'b0, 32'h0, 1'b1);
    check("ovr s2 jtag_overrun", 32'(ovr), 32'h0);
    next();
    clr(); ta_b = 1'b1; jdo = mk_jdo(1'b1, 8'h00, 1'b0, 32'h9999_9999);
    #3;
    chk_ram("ovr s3", 8'h00, 1'b0, 32'h0, 1'b1);
    check("ovr s3 jtag_overrun", 32'(ovr), 32'h0);
    next();
    clr();
    #3;
    chk_ram("ovr held wr", 8'h04, 1'b1, 32'h7777_7777, 1'b1);
    chk_jtag("ovr held wr", 32'h1000_0003, 1'b1, 1'b1);
    next();
    clr();
    #3;
    chk_ram("ovr dropped", 8'h00, 1'b0, 32'h0, 1'b1);
    check("ovr sticky jtag_overrun", 32'(ovr), 32'h1);
    next();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
